axi4_xbar: RTL
==============

AXI4_XBAR -- requirements
Module: axi4_xbar

Interface
REQ-001 SHALL have parameter S0_BASE, 32'h8000_0000, match base for slave 0.
REQ-002 SHALL have parameter S0_MASK, 32'hF800_0000, match mask for slave 0.
REQ-003 SHALL have parameter S1_BASE, 32'h1000_0000, match base for slave 1.
REQ-004 SHALL have parameter S1_MASK, 32'hF000_0000, match mask for slave 1.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port m  axi4_interface.slave  bundle  upstream master. Field widths: addr 32, data 32, id 4, len 8, size 3, burst 2, resp 2, strb 4.
REQ-008 SHALL have ports s0 and s1  axi4_interface.master  bundle  downstream slaves. Field widths are the same as for m.

Function
REQ-009 SHALL decode addresses as follows:
- Target is s0 if (addr & S0_MASK)==S0_BASE.
- Otherwise target is s1 if (addr & S1_MASK)==S1_BASE.
- Otherwise the access is a decode error (DECERR).
- s0 wins if both match.
REQ-010 SHALL run independent read and write FSMs. A read and a write may be in flight at once, to the same or different slaves.
REQ-011 SHALL drive all outputs to a non-selected slave, and all master-side outputs of an idle channel, to 0.
REQ-012 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA, R_ERR_AR, R_ERR_DATA.
REQ-013 R_IDLE SHALL hold m.arready=0.
- On m.arvalid, latch the decoded target.
- Go to R_ADDR for s0/s1, or to R_ERR_AR on DECERR.
- Decode latency is 1 cycle.
REQ-014 R_ADDR SHALL combinationally forward AR fields/arvalid to the target and arready back to m. It goes to R_DATA on the arvalid&arready cycle.
REQ-015 R_DATA SHALL combinationally forward the R channel (rdata, rresp, rid, rlast, rvalid; rready back). It returns to R_IDLE on the rvalid&rready&rlast cycle.
REQ-016 R_ERR_AR SHALL assert m.arready for exactly one cycle, latch arid and arlen, clear the beat counter, then go to R_ERR_DATA.
REQ-017 R_ERR_DATA SHALL drive:
- m.rvalid=1, rdata=0, rresp=2'b11, rid=latched id.
- rlast=1 when the 8-bit beat counter equals the latched len.
The counter increments on each rvalid&rready. After the last beat is accepted, return to R_IDLE.
REQ-018 Write FSM states SHALL be W_IDLE, W_FWD, W_RESP, W_ERR, W_ERR_RESP.
REQ-019 W_IDLE SHALL hold m.awready=m.wready=0.
- On m.awvalid, latch the target.
- Go to W_FWD, or to W_ERR on DECERR.
REQ-020 W_FWD SHALL combinationally forward the AW and W channels to the target. aw_done is set on awvalid&awready, and AW is gated off while aw_done=1.
REQ-021 W_FWD SHALL go to W_RESP when AW is done (earlier or this cycle) and W is done (wvalid&wready&wlast, this cycle or latched earlier).
REQ-022 W_RESP SHALL forward the B channel (bresp, bid, bvalid; bready back). It returns to W_IDLE on bvalid&bready.
REQ-023 W_ERR SHALL:
- assert m.awready for the first cycle only, latching awid;
- assert m.wready continuously, discarding data;
- go to W_ERR_RESP once aw_done and the wlast beat are accepted.
REQ-024 W_ERR_RESP SHALL drive m.bvalid=1, bresp=2'b11, bid=latched id. It returns to W_IDLE on bready.
REQ-025 SHALL NOT re-decode or switch target mid-transaction. Address changes on m during a transaction SHALL be ignored until the FSM is idle.
REQ-026 The beat counter SHALL allow arlen=8'hFF (256 beats) without overflow affecting rlast.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately clear:
- both FSMs to idle;
- aw_done, w_done, the beat counter and the latched ids/len;
- all valid/ready outputs on m, s0 and s1.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no completion beat issued after deassertion.
REQ-029 After rst_n rises, the first arvalid/awvalid SHALL be decoded no earlier than the next rising clk edge.

Verification
REQ-030 Read araddr=32'h8000_0010, arlen=0, s0 returns rdata=32'hDEADBEEF, rresp=0 -> s0 sees the AR and m receives DEADBEEF with rlast=1; s1 stays idle.
REQ-031 Write awaddr=32'h1000_0004, wdata=32'h1234_5678, wstrb=4'hF, W presented 2 cycles before AW -> s1 gets both channels, m gets bresp=0 with bid matching awid.
REQ-032 Read araddr=32'h0000_0000, arid=4'h5, arlen=3 -> 4 beats with rresp=2'b11 and rid=5, rlast only on beat 4; neither slave sees arvalid.
REQ-033 Write awaddr=32'h4000_0000, 2 beats -> both beats absorbed, then bresp=2'b11; no slave activity.
REQ-034 Concurrent read from s1 and write to s0, with rready/bready held low 3 cycles -> both complete independently, and valid signals are held stable until accepted.
REQ-035 rst_n pulsed low during R_DATA beat 2 of 4 -> all valids/readies are 0 asynchronously, and the next read completes normally.

Source files
------------

// File: rtl/axi4_xbar.sv
// axi4_xbar: one AXI4 master to two AXI4 slaves with address decode.
// Reads and writes use independent FSMs. Unmatched addresses get a
// locally generated DECERR response.
module axi4_xbar #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'h1000_0000,
    parameter logic [31:0] S1_MASK = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // upstream master
    input  logic [31:0] m_awaddr,
    input  logic [3:0]  m_awid,
    input  logic [7:0]  m_awlen,
    input  logic [2:0]  m_awsize,
    input  logic [1:0]  m_awburst,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_wlast,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [3:0]  m_bid,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    input  logic [31:0] m_araddr,
    input  logic [3:0]  m_arid,
    input  logic [7:0]  m_arlen,
    input  logic [2:0]  m_arsize,
    input  logic [1:0]  m_arburst,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [3:0]  m_rid,
    output logic [31:0] m_rdata,
    output logic [1:0]  m_rresp,
    output logic        m_rlast,
    output logic        m_rvalid,
    input  logic        m_rready,
    // downstream slave 0
    output logic [31:0] s0_awaddr,
    output logic [3:0]  s0_awid,
    output logic [7:0]  s0_awlen,
    output logic [2:0]  s0_awsize,
    output logic [1:0]  s0_awburst,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    output logic        s0_wlast,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [3:0]  s0_bid,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    output logic [31:0] s0_araddr,
    output logic [3:0]  s0_arid,
    output logic [7:0]  s0_arlen,
    output logic [2:0]  s0_arsize,
    output logic [1:0]  s0_arburst,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [3:0]  s0_rid,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rlast,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    // downstream slave 1
    output logic [31:0] s1_awaddr,
    output logic [3:0]  s1_awid,
    output logic [7:0]  s1_awlen,
    output logic [2:0]  s1_awsize,
    output logic [1:0]  s1_awburst,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [3:0]  s1_wstrb,
    output logic        s1_wlast,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [3:0]  s1_bid,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready,
    output logic [31:0] s1_araddr,
    output logic [3:0]  s1_arid,
    output logic [7:0]  s1_arlen,
    output logic [2:0]  s1_arsize,
    output logic [1:0]  s1_arburst,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [3:0]  s1_rid,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rlast,
    input  logic        s1_rvalid,
    output logic        s1_rready
);

    localparam logic [2:0] R_IDLE     = 3'd0;
    localparam logic [2:0] R_ADDR     = 3'd1;
    localparam logic [2:0] R_DATA     = 3'd2;
    localparam logic [2:0] R_ERR_AR   = 3'd3;
    localparam logic [2:0] R_ERR_DATA = 3'd4;

    localparam logic [2:0] W_IDLE     = 3'd0;
    localparam logic [2:0] W_FWD      = 3'd1;
    localparam logic [2:0] W_RESP     = 3'd2;
    localparam logic [2:0] W_ERR      = 3'd3;
    localparam logic [2:0] W_ERR_RESP = 3'd4;

    localparam logic [1:0] T_S0  = 2'd0;
    localparam logic [1:0] T_S1  = 2'd1;
    localparam logic [1:0] T_ERR = 2'd2;

    logic [2:0] r_state, w_state;
    logic       r_tgt, w_tgt;          // 0 = s0, 1 = s1
    logic [7:0] r_cnt, r_len;
    logic [3:0] r_id, w_id;
    logic       aw_done, w_done;
    logic [1:0] ar_dec, aw_dec;
    logic       aw_fire, wl_fire;

    // s0 takes priority when both windows match
    function automatic logic [1:0] decode(input logic [31:0] a);
        if ((a & S0_MASK) == S0_BASE)      return T_S0;
        else if ((a & S1_MASK) == S1_BASE) return T_S1;
        else                               return T_ERR;
    endfunction

    assign ar_dec  = decode(m_araddr);
    assign aw_dec  = decode(m_awaddr);
    assign aw_fire = m_awvalid & m_awready;
    assign wl_fire = m_wvalid & m_wready & m_wlast;

    // Read FSM: latch target on idle, then forward or generate DECERR beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            r_tgt   <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_id    <= '0;
        end else begin
            case (r_state)
                R_IDLE: if (m_arvalid) begin
                    if (ar_dec == T_ERR) r_state <= R_ERR_AR;
                    else begin
                        r_tgt   <= ar_dec[0];
                        r_state <= R_ADDR;
                    end
                end
                R_ADDR: if (m_arvalid && m_arready) r_state <= R_DATA;
                R_DATA: if (m_rvalid && m_rready && m_rlast) r_state <= R_IDLE;
                R_ERR_AR: begin
                    r_id    <= m_arid;
                    r_len   <= m_arlen;
                    r_cnt   <= '0;
                    r_state <= R_ERR_DATA;
                end
                R_ERR_DATA: if (m_rready) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == r_len) r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write FSM: AW and W complete in either order before the response phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
            w_tgt   <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_id    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (m_awvalid) begin
                        if (aw_dec == T_ERR) w_state <= W_ERR;
                        else begin
                            w_tgt   <= aw_dec[0];
                            w_state <= W_FWD;
                        end
                    end
                end
                W_FWD, W_ERR: begin
                    if (aw_fire) aw_done <= 1'b1;
                    if (aw_fire && w_state == W_ERR) w_id <= m_awid;
                    if (wl_fire) w_done <= 1'b1;
                    if ((aw_done || aw_fire) && (w_done || wl_fire))
                        w_state <= (w_state == W_ERR) ? W_ERR_RESP : W_RESP;
                end
                W_RESP:     if (m_bvalid && m_bready) w_state <= W_IDLE;
                W_ERR_RESP: if (m_bready) w_state <= W_IDLE;
                default:    w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel steering; everything not selected is held at zero
    always_comb begin
        m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
        s0_araddr = '0; s0_arid = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0;
        s0_arvalid = 1'b0; s0_rready = 1'b0;
        s1_araddr = '0; s1_arid = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0;
        s1_arvalid = 1'b0; s1_rready = 1'b0;
        case (r_state)
            R_ADDR: if (r_tgt) begin
                s1_araddr = m_araddr; s1_arid = m_arid; s1_arlen = m_arlen;
                s1_arsize = m_arsize; s1_arburst = m_arburst; s1_arvalid = m_arvalid;
                m_arready = s1_arready;
            end else begin
                s0_araddr = m_araddr; s0_arid = m_arid; s0_arlen = m_arlen;
                s0_arsize = m_arsize; s0_arburst = m_arburst; s0_arvalid = m_arvalid;
                m_arready = s0_arready;
            end
            R_DATA: if (r_tgt) begin
                m_rid = s1_rid; m_rdata = s1_rdata; m_rresp = s1_rresp;
                m_rlast = s1_rlast; m_rvalid = s1_rvalid; s1_rready = m_rready;
            end else begin
                m_rid = s0_rid; m_rdata = s0_rdata; m_rresp = s0_rresp;
                m_rlast = s0_rlast; m_rvalid = s0_rvalid; s0_rready = m_rready;
            end
            R_ERR_AR: m_arready = 1'b1;
            R_ERR_DATA: begin
                m_rvalid = 1'b1;
                m_rresp  = 2'b11;
                m_rid    = r_id;
                m_rlast  = (r_cnt == r_len);
            end
            default: ;
        endcase
    end

    // Write channel steering; AW is gated once accepted, W once wlast accepted
    always_comb begin
        m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;
        s0_awaddr = '0; s0_awid = '0; s0_awlen = '0; s0_awsize = '0; s0_awburst = '0; s0_awvalid = 1'b0;
        s0_wdata = '0; s0_wstrb = '0; s0_wlast = 1'b0; s0_wvalid = 1'b0; s0_bready = 1'b0;
        s1_awaddr = '0; s1_awid = '0; s1_awlen = '0; s1_awsize = '0; s1_awburst = '0; s1_awvalid = 1'b0;
        s1_wdata = '0; s1_wstrb = '0; s1_wlast = 1'b0; s1_wvalid = 1'b0; s1_bready = 1'b0;
        case (w_state)
            W_FWD: if (w_tgt) begin
                s1_awaddr = m_awaddr; s1_awid = m_awid; s1_awlen = m_awlen;
                s1_awsize = m_awsize; s1_awburst = m_awburst;
                s1_awvalid = m_awvalid & ~aw_done; m_awready = s1_awready & ~aw_done;
                s1_wdata = m_wdata; s1_wstrb = m_wstrb; s1_wlast = m_wlast;
                s1_wvalid = m_wvalid & ~w_done; m_wready = s1_wready & ~w_done;
            end else begin
                s0_awaddr = m_awaddr; s0_awid = m_awid; s0_awlen = m_awlen;
                s0_awsize = m_awsize; s0_awburst = m_awburst;
                s0_awvalid = m_awvalid & ~aw_done; m_awready = s0_awready & ~aw_done;
                s0_wdata = m_wdata; s0_wstrb = m_wstrb; s0_wlast = m_wlast;
                s0_wvalid = m_wvalid & ~w_done; m_wready = s0_wready & ~w_done;
            end
            W_RESP: if (w_tgt) begin
                m_bid = s1_bid; m_bresp = s1_bresp; m_bvalid = s1_bvalid; s1_bready = m_bready;
            end else begin
                m_bid = s0_bid; m_bresp = s0_bresp; m_bvalid = s0_bvalid; s0_bready = m_bready;
            end
            W_ERR: begin
                m_awready = ~aw_done;
                m_wready  = 1'b1;
            end
            W_ERR_RESP: begin
                m_bvalid = 1'b1;
                m_bresp  = 2'b11;
                m_bid    = w_id;
            end
            default: ;
        endcase
    end

endmodule
